// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with prioritised dual writeback, optional bypass and busy scoreboard
// Ports: clock, reset_n (asynchronous active-low)
//        rd_addr / rd_data / rd_busy : NUM_RD packed combinational read ports
//        wr0_* / wr1_*               : writeback ports, wr1 wins on the same address
//        iss_en / iss_addr           : mark a destination register busy
//        busy_cnt                    : registered count of busy registers
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [ADDR_W:0]          busy_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              w0_ok, w1_ok, iss_ok;
    // A hard-wired register 0 swallows writes and issues entirely.
    assign w0_ok  = wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
    assign w1_ok  = wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);
    assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == '0);
    always_comb begin
        busy_nxt = busy;
        if (w0_ok) busy_nxt[wr0_addr] = 1'b0;
        if (w1_ok) busy_nxt[wr1_addr] = 1'b0;
        // Issue is applied last: the new producer supersedes the retiring one.
        if (iss_ok) busy_nxt[iss_addr] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (w0_ok) mem[wr0_addr] <= wr0_data;
            // Later non-blocking assignment gives port 1 priority on collisions.
            if (w1_ok) mem[wr1_addr] <= wr1_data;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit0, hit1, iss_hit;
        assign a       = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit0    = BYPASS != 0 && w0_ok && wr0_addr == a;
        assign hit1    = BYPASS != 0 && w1_ok && wr1_addr == a;
        assign iss_hit = iss_ok && iss_addr == a;
        assign rd_data[k*DATA_W +: DATA_W] = (ZERO_REG != 0 && a == '0) ? '0 :
                                             hit1 ? wr1_data : hit0 ? wr0_data : mem[a];
        // A retiring write frees the register early unless it is being re-issued.
        assign rd_busy[k] = ((hit0 || hit1) && !iss_hit) ? 1'b0 : busy[a];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized reference-model bench for reg_file_mp plus directed configuration checks
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [9:0]  ra;
    logic [63:0] rdd;
    logic [1:0]  rb;
    logic        w0e, w1e, ie;
    logic [4:0]  w0a, w1a, ia;
    logic [31:0] w0d, w1d;
    logic [5:0]  bc;

    logic [11:0] ra4;
    logic [63:0] rdd4;
    logic [3:0]  rb4;
    logic        w4e;
    logic [2:0]  w4a;
    logic [15:0] w4d;
    logic [3:0]  bc4;

    logic [9:0]  ra0;
    logic [63:0] rdd0;
    logic [1:0]  rb0;
    logic        z0e, zie;
    logic [4:0]  z0a, zia;
    logic [31:0] z0d;
    logic [5:0]  bc0;

    reg_file_mp u_a (
        .clock(clk), .reset_n(rst_n), .rd_addr(ra), .rd_data(rdd), .rd_busy(rb),
        .wr0_en(w0e), .wr0_addr(w0a), .wr0_data(w0d),
        .wr1_en(w1e), .wr1_addr(w1a), .wr1_data(w1d),
        .iss_en(ie), .iss_addr(ia), .busy_cnt(bc)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_4 (
        .clock(clk), .reset_n(rst_n), .rd_addr(ra4), .rd_data(rdd4), .rd_busy(rb4),
        .wr0_en(w4e), .wr0_addr(w4a), .wr0_data(w4d),
        .wr1_en(1'b0), .wr1_addr(3'd0), .wr1_data(16'd0),
        .iss_en(1'b0), .iss_addr(3'd0), .busy_cnt(bc4)
    );

    reg_file_mp #(.BYPASS(0), .ZERO_REG(0)) u_0 (
        .clock(clk), .reset_n(rst_n), .rd_addr(ra0), .rd_data(rdd0), .rd_busy(rb0),
        .wr0_en(z0e), .wr0_addr(z0a), .wr0_data(z0d),
        .wr1_en(1'b0), .wr1_addr(5'd0), .wr1_data(32'd0),
        .iss_en(zie), .iss_addr(zia), .busy_cnt(bc0)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_mem [32];
    bit          m_busy [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (w1e && w1a == a) return w1d;
        if (w0e && w0a == a) return w0d;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (((w0e && w0a == a) || (w1e && w1a == a)) && !(ie && ia == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [15:0] val4(input int a);
        return (a == 0) ? 16'd0 : 16'h1000 + 16'(a) * 16'h0111;
    endfunction

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    task automatic model_clear();
        foreach (m_mem[i]) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int a = 1; a < 32; a++) begin
            if (ie && ia == 5'(a)) m_busy[a] = 1'b1;
            else if ((w0e && w0a == 5'(a)) || (w1e && w1a == 5'(a))) m_busy[a] = 1'b0;
        end
        if (w0e && w0a != 5'd0) m_mem[w0a] = w0d;
        if (w1e && w1a != 5'd0) m_mem[w1a] = w1d;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd_data[%0d]", k), 64'(rdd[k*32 +: 32]), 64'(exp_data(ra[k*5 +: 5])));
            chk($sformatf("rd_busy[%0d]", k), 64'(rb[k]), 64'(exp_busy(ra[k*5 +: 5])));
        end
        chk("busy_cnt", 64'(bc), 64'(exp_cnt()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        w0e = 1'b0; w1e = 1'b0; ie = 1'b0; w4e = 1'b0; z0e = 1'b0; zie = 1'b0;
    endtask

    initial begin
        idle();
        ra = '0; ra4 = '0; ra0 = '0;
        w0a = '0; w1a = '0; ia = '0; w0d = '0; w1d = '0;
        w4a = '0; w4d = '0; z0a = '0; zia = '0; z0d = '0;
        model_clear();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        chk("reset busy_cnt", 64'(bc), 64'd0);
        tick();
        // load R5 and mark it busy, then reset between edges
        w0e = 1'b1; w0a = 5'd5; w0d = 32'hDEADBEEF; ie = 1'b1; ia = 5'd5; ra = {5'd0, 5'd5};
        settle();
        tick();
        idle();
        settle();
        chk("R5 loaded", 64'(rdd[31:0]), 64'hDEADBEEF);
        chk("R5 busy", 64'(rb[0]), 64'd1);
        chk("R5 busy_cnt", 64'(bc), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset R5 data", 64'(rdd[31:0]), 64'd0);
        chk("async reset R5 busy", 64'(rb[0]), 64'd0);
        chk("async reset busy_cnt", 64'(bc), 64'd0);
        model_clear();
        #1 rst_n = 1'b1;
        tick();
        // dual write collision on R7
        w0e = 1'b1; w0a = 5'd7; w0d = 32'h11111111;
        w1e = 1'b1; w1a = 5'd7; w1d = 32'h22222222; ra = {5'd7, 5'd7};
        settle();
        chk("collision bypass", 64'(rdd[63:32]), 64'h22222222);
        tick();
        idle();
        settle();
        chk("collision stored", 64'(rdd[31:0]), 64'h22222222);
        tick();
        // register 0 write plus issue
        w0e = 1'b1; w0a = 5'd0; w0d = 32'hFFFFFFFF; ie = 1'b1; ia = 5'd0; ra = {5'd0, 5'd0};
        settle();
        chk("R0 bypass data", 64'(rdd[63:32]), 64'd0);
        chk("R0 bypass busy", 64'(rb[1]), 64'd0);
        tick();
        idle();
        settle();
        chk("R0 data", 64'(rdd[31:0]), 64'd0);
        chk("R0 busy", 64'(rb[0]), 64'd0);
        chk("R0 busy_cnt", 64'(bc), 64'd0);
        tick();
        // scoreboard race on R3
        ie = 1'b1; ia = 5'd3; ra = {5'd3, 5'd3};
        settle();
        tick();
        idle();
        settle();
        chk("R3 busy", 64'(rb[0]), 64'd1);
        chk("R3 busy_cnt", 64'(bc), 64'd1);
        tick();
        ie = 1'b1; ia = 5'd3; w0e = 1'b1; w0a = 5'd3; w0d = 32'h0000ABCD;
        settle();
        chk("race pre-edge busy", 64'(rb[0]), 64'd1);
        tick();
        idle();
        settle();
        chk("race busy held", 64'(rb[0]), 64'd1);
        chk("race busy_cnt", 64'(bc), 64'd1);
        tick();
        w1e = 1'b1; w1a = 5'd3; w1d = 32'h00000005;
        settle();
        chk("wr1 bypass busy", 64'(rb[0]), 64'd0);
        tick();
        idle();
        settle();
        chk("wr1 busy cleared", 64'(rb[0]), 64'd0);
        chk("wr1 busy_cnt", 64'(bc), 64'd0);
        chk("wr1 R3 data", 64'(rdd[31:0]), 64'd5);
        tick();
        // randomized traffic against the model
        repeat (400) begin
            w0e = ($urandom_range(0, 2) != 0); w0a = rnd_addr(); w0d = $urandom;
            w1e = ($urandom_range(0, 2) == 0); w1a = rnd_addr(); w1d = $urandom;
            ie  = ($urandom_range(0, 1) != 0); ia  = rnd_addr();
            ra  = {rnd_addr(), rnd_addr()};
            settle();
            tick();
        end
        idle();
        // BYPASS=0, ZERO_REG=0 instance
        z0e = 1'b1; z0a = 5'd9; z0d = 32'h12345678; ra0 = {5'd9, 5'd9};
        settle();
        chk("nobyp old value", 64'(rdd0[31:0]), 64'd0);
        tick();
        z0e = 1'b0;
        settle();
        chk("nobyp new value", 64'(rdd0[31:0]), 64'h12345678);
        tick();
        zie = 1'b1; zia = 5'd9;
        settle();
        tick();
        zie = 1'b0; z0e = 1'b1; z0a = 5'd9; z0d = 32'd1;
        settle();
        chk("nobyp busy pre-edge", 64'(rb0[0]), 64'd1);
        tick();
        z0e = 1'b0;
        settle();
        chk("nobyp busy cleared", 64'(rb0[0]), 64'd0);
        chk("nobyp busy_cnt", 64'(bc0), 64'd0);
        chk("nobyp R9 data", 64'(rdd0[31:0]), 64'd1);
        tick();
        z0e = 1'b1; z0a = 5'd0; z0d = 32'h000000A5; zie = 1'b1; zia = 5'd0; ra0 = {5'd0, 5'd0};
        settle();
        chk("R0 writable pre-edge", 64'(rdd0[31:0]), 64'd0);
        tick();
        idle();
        settle();
        chk("R0 writable data", 64'(rdd0[31:0]), 64'hA5);
        chk("R0 writable busy", 64'(rb0[1]), 64'd1);
        chk("R0 writable busy_cnt", 64'(bc0), 64'd1);
        tick();
        // four-port instance
        for (int i = 1; i < 8; i++) begin
            w4e = 1'b1; w4a = 3'(i); w4d = val4(i); ra4 = {4{3'(i)}};
            settle();
            chk($sformatf("mp bypass R%0d", i), 64'(rdd4[63:48]), 64'(val4(i)));
            tick();
        end
        idle();
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 4; k++) ra4[k*3 +: 3] = (n == 0) ? 3'd5 : 3'($urandom_range(0, 7));
            settle();
            for (int k = 0; k < 4; k++)
                chk($sformatf("mp port%0d addr%0d", k, ra4[k*3 +: 3]), 64'(rdd4[k*16 +: 16]),
                    64'(val4(int'(ra4[k*3 +: 3]))));
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the pipelined MIPS datapath, the successor to the single-cycle 32×32 file. It provides configurable data width and depth, N combinational read ports, two prioritised write ports, and optional same-cycle write-to-read bypass. A per-register busy scoreboard lets the issue stage detect RAW hazards. Register 0 is hard-wired to zero when enabled.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never busy
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy  out  NUM_RD  busy bit of each read address
- wr0_en, wr0_addr, wr0_data  in  1, ADDR_W, DATA_W  write port 0 (ALU writeback)
- wr1_en, wr1_addr, wr1_data  in  1, ADDR_W, DATA_W  write port 1 (load writeback); wins over port 0 on the same address
- iss_en, iss_addr  in  1, ADDR_W  issue: mark destination register busy
- busy_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: depth × DATA_W array plus a depth-bit busy vector.
- Reset (reset_n=0, asynchronous): all registers clear to 0 and all busy bits clear to 0, so busy_cnt=0. rd_data and rd_busy then reflect cleared state combinationally. Reset asserted mid-cycle discards any pending write or issue.
- Write: on a rising edge, if wrX_en is set, the array entry at wrX_addr gets wrX_data. If both ports target the same address, wr1_data is stored. Writes to address 0 are dropped when ZERO_REG=1.
- Read (combinational):
  - rd_data[k] = array[rd_addr[k]].
  - When BYPASS=1 and a write is enabled this cycle to rd_addr[k], rd_data[k] = that write's data instead, using port-1 priority.
  - When ZERO_REG=1 and rd_addr[k]=0, rd_data[k]=0 regardless of other inputs.
- Scoreboard, per address, on a rising edge:
  - set if iss_en and iss_addr matches;
  - else clear if any enabled write port targets it;
  - else hold.
  - Issue beats writeback on the same address, because the new producer supersedes the old one.
  - Address 0 is never set when ZERO_REG=1.
- rd_busy[k] = busy[rd_addr[k]]. With BYPASS=1, a same-cycle write to that address forces rd_busy[k]=0 unless the same-cycle issue also targets it.
- busy_cnt is a registered population count, updated on the same edge as the busy vector and consistent with it at all times.

## Timing
- Write and issue latency: 1 clock edge. The stored value is visible on rd_data in the cycle after the edge, or in the same cycle through the bypass.
- Read latency: 0 cycles, combinational from rd_addr and write inputs.
- No handshake. The scoreboard does not block writes; stalling is the pipeline's responsibility.
- No clock gating. All state is on clock's rising edge or the falling edge of reset_n.

## Test plan
- Reset: load R5=0xDEADBEEF, set R5 busy, then pulse reset_n low between edges → rd_data for R5 reads 0 immediately, rd_busy=0, busy_cnt=0.
- Dual write collision: wr0 (R7, 0x11111111) and wr1 (R7, 0x22222222) in the same cycle → after the edge R7=0x22222222. With BYPASS=1, a same-cycle read of R7 returns 0x22222222 before the edge.
- Zero register: wr0 (R0, 0xFFFFFFFF) with iss_en (R0) → R0 reads 0, rd_busy=0, busy_cnt unchanged.
- Scoreboard race: R3 busy, then issue R3 and wr0 R3 in the same cycle → R3 stays busy and busy_cnt is unchanged. Next cycle wr1 R3 alone → busy clears and busy_cnt decrements by 1.
- Multi-port read with NUM_RD=4, DATA_W=16, ADDR_W=3: write distinct values to R1–R7 → all four ports return the correct values simultaneously for arbitrary address combinations, including all four ports reading the same address.
- BYPASS=0: write R9=0x12345678 → same-cycle read returns the old value 0, and the next cycle returns 0x12345678.
